// File: rtl/exception_unit.sv
// Commit-stage exception arbiter: fixed-priority MIPS event selection plus a post-redirect flush sequencer.
// Optional macro EXC_INT_SYNC_EN adds a 2-flop synchronizer on ext_int (2-cycle latency instead of 1).
module exception_unit #(
    parameter int unsigned FLUSH_CYCLES      = 2,
    parameter logic [31:0] RESET_VECTOR_BASE = 32'hBFC00200,
    parameter logic [31:0] NORMAL_BASE       = 32'h80000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  ext_int,
    input  logic        timer_interrupt,
    input  logic        cp0_ie,
    input  logic        cp0_exl,
    input  logic        cp0_erl,
    input  logic        cp0_bev,
    input  logic [7:0]  cp0_im,
    input  logic [1:0]  cp0_ip_sw,
    input  logic        cp0_iv,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic [31:0] commit_pc,
    input  logic        commit_in_delay_slot,
    input  logic [31:0] commit_mem_vaddr,
    input  logic        f_adel_if,
    input  logic        f_tlbl_if,
    input  logic        f_refill_if,
    input  logic        f_ri,
    input  logic        f_cpu,
    input  logic        f_sys,
    input  logic        f_bp,
    input  logic        f_ov,
    input  logic        f_adel,
    input  logic        f_ades,
    input  logic        f_tlbl,
    input  logic        f_tlbs,
    input  logic        f_mod,
    input  logic        f_refill_mem,
    input  logic        f_eret,
    input  logic [1:0]  f_ce,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_pc,
    output logic        exc_in_delay_slot,
    output logic [31:0] exc_badvaddr,
    output logic [31:0] exc_location,
    output logic [1:0]  exc_ce,
    output logic        is_eret,
    output logic [7:0]  interrupt_info,
    output logic        flush
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [5:0]  r_ext_q;

`ifdef EXC_INT_SYNC_EN
    logic [5:0]  r_ext_s1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ext_s1 <= '0;
            r_ext_q  <= '0;
        end else begin
            r_ext_s1 <= ext_int;
            r_ext_q  <= r_ext_s1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ext_q <= '0;
        end else begin
            r_ext_q <= ext_int;
        end
    end
`endif

    logic        w_idle;
    logic        w_int_pending;
    logic        w_any;
    logic        w_is_int;
    logic        w_refill;
    logic [4:0]  w_code;
    logic [31:0] w_badvaddr;
    logic [1:0]  w_ce;
    logic [31:0] w_base;
    logic [31:0] w_offset;

    assign w_idle         = (r_state == IDLE);
    assign interrupt_info = {r_ext_q[5] | timer_interrupt, r_ext_q[4:0], cp0_ip_sw};
    assign w_int_pending  = cp0_ie & ~cp0_exl & ~cp0_erl & (|(interrupt_info & cp0_im));

    // Fixed MIPS priority; w_any excludes ERET so an exception with ERET set wins.
    always_comb begin
        w_any      = 1'b1;
        w_is_int   = 1'b0;
        w_refill   = 1'b0;
        w_code     = '0;
        w_badvaddr = '0;
        w_ce       = '0;
        if (w_int_pending) begin
            w_is_int = 1'b1;
            w_code   = 5'd0;
        end else if (f_adel_if) begin
            w_code     = 5'd4;
            w_badvaddr = commit_pc;
        end else if (f_tlbl_if) begin
            w_code     = 5'd2;
            w_badvaddr = commit_pc;
            w_refill   = f_refill_if;
        end else if (f_ri) begin
            w_code = 5'd10;
        end else if (f_cpu) begin
            w_code = 5'd11;
            w_ce   = f_ce;
        end else if (f_sys) begin
            w_code = 5'd8;
        end else if (f_bp) begin
            w_code = 5'd9;
        end else if (f_ov) begin
            w_code = 5'd12;
        end else if (f_adel) begin
            w_code     = 5'd4;
            w_badvaddr = commit_mem_vaddr;
        end else if (f_ades) begin
            w_code     = 5'd5;
            w_badvaddr = commit_mem_vaddr;
        end else if (f_tlbl) begin
            w_code     = 5'd2;
            w_badvaddr = commit_mem_vaddr;
            w_refill   = f_refill_mem;
        end else if (f_tlbs) begin
            w_code     = 5'd3;
            w_badvaddr = commit_mem_vaddr;
            w_refill   = f_refill_mem;
        end else if (f_mod) begin
            w_code     = 5'd1;
            w_badvaddr = commit_mem_vaddr;
        end else begin
            w_any = 1'b0;
        end
    end

    always_comb begin
        w_base = cp0_bev ? RESET_VECTOR_BASE : NORMAL_BASE;
        if (w_refill && !cp0_exl) begin
            w_offset = 32'h000;
        end else if (w_is_int && cp0_iv) begin
            w_offset = 32'h200;
        end else begin
            w_offset = 32'h180;
        end
    end

    assign exc_location      = w_base + w_offset;
    assign exc_valid         = w_idle & commit_valid & w_any;
    assign is_eret           = w_idle & commit_valid & f_eret & ~exc_valid;
    assign exc_code          = exc_valid ? w_code : '0;
    assign exc_pc            = exc_valid ? commit_pc : '0;
    assign exc_in_delay_slot = exc_valid & commit_in_delay_slot;
    assign exc_badvaddr      = exc_valid ? w_badvaddr : '0;
    assign exc_ce            = exc_valid ? w_ce : '0;
    assign flush             = exc_valid | is_eret | (r_state == FLUSH);
    assign commit_ready      = w_idle;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (exc_valid || is_eret) begin
                        r_state <= FLUSH;
                        r_cnt   <= 4'(FLUSH_CYCLES - 1);
                    end
                end
                FLUSH: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/exception_unit.md
Name: exception_unit

Overview:
- Commit-stage exception arbiter; sits directly upstream of the CP0 register file.
- Collects per-instruction exception flags from the commit stage, ERET, external interrupts and the CP0 timer interrupt.
- Picks one winning event by fixed MIPS priority and drives the exception record CP0 consumes: valid, code, pc, delay-slot bit, badvaddr, vector location, CE.
- Runs a post-redirect flush sequencer that blocks commit while the pipeline drains.

Parameters:
- FLUSH_CYCLES, 2, cycles commit stays blocked after a redirect (1..15).
- RESET_VECTOR_BASE, 32'hBFC00200, exception base when Status.BEV=1.
- NORMAL_BASE, 32'h80000000, exception base when Status.BEV=0.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- ext_int  in  6  asynchronous hardware interrupt lines.
- timer_interrupt  in  1  CP0 timer pending.
- cp0_ie, cp0_exl, cp0_erl, cp0_bev  in  1 each  Status bits.
- cp0_im  in  8  Status.IM.
- cp0_ip_sw  in  2  Cause.IP[1:0].
- cp0_iv  in  1  Cause.IV.
- commit_valid  in  1  instruction present at commit.
- commit_ready  out  1  commit may retire.
- commit_pc  in  32  instruction PC.
- commit_in_delay_slot  in  1  instruction is in a delay slot.
- commit_mem_vaddr  in  32  data address.
- f_adel_if, f_tlbl_if, f_refill_if, f_ri, f_cpu, f_sys, f_bp, f_ov, f_adel, f_ades, f_tlbl, f_tlbs, f_mod, f_refill_mem, f_eret  in  1 each  exception flags.
- f_ce  in  2  coprocessor number for CpU.
- exc_valid  out  1  exception taken this cycle.
- exc_code  out  5  ExcCode.
- exc_pc  out  32  faulting PC.
- exc_in_delay_slot  out  1  delay-slot bit.
- exc_badvaddr  out  32  faulting address.
- exc_location  out  32  handler vector.
- exc_ce  out  2  Cause.CE value.
- is_eret  out  1  ERET committed.
- interrupt_info  out  8  IP bits for CP0; [7:2] used by CP0.
- flush  out  1  kill younger pipeline stages.

Behaviour:
- Interrupt path: ext_int is registered into ext_q; interrupt_info = {ext_q[5]|timer_interrupt, ext_q[4:0], cp0_ip_sw}.
- int_pending = cp0_ie & ~cp0_exl & ~cp0_erl & |(interrupt_info & cp0_im).
- Interrupts attach only to an instruction with commit_valid=1.
- Priority, highest first:
  - Int (0).
  - AdEL fetch (4); badvaddr = pc.
  - TLBL fetch (2); badvaddr = pc.
  - RI (10).
  - CpU (11); exc_ce = f_ce.
  - Sys (8).
  - Bp (9).
  - Ov (12).
  - AdEL mem (4).
  - AdES mem (5).
  - TLBL mem (2).
  - TLBS mem (3).
  - Mod (1).
- Mem-side codes use badvaddr = commit_mem_vaddr. Otherwise exc_badvaddr = 0 and exc_ce = 0.
- exc_valid = state==IDLE & commit_valid & (int_pending | any flag except f_eret). It is combinational the same cycle; CP0 samples it on the next edge.
- is_eret = state==IDLE & commit_valid & f_eret & ~exc_valid. An exception with ERET set wins.
- exc_pc = commit_pc; exc_in_delay_slot = commit_in_delay_slot. CP0 performs the EPC −4 adjustment.
- exc_location:
  - Base: BEV ? RESET_VECTOR_BASE : NORMAL_BASE.
  - Offset 0x000 when the winner is a TLB refill (f_refill_if/f_refill_mem with the matching TLB flag) and cp0_exl=0.
  - Offset 0x200 when code=Int and cp0_iv=1.
  - Otherwise offset 0x180.
- FSM states IDLE, FLUSH:
  - IDLE → FLUSH on exc_valid | is_eret; counter loads FLUSH_CYCLES−1.
  - FLUSH decrements each cycle and returns to IDLE after the cycle in which the counter reads 0.
- flush = exc_valid | is_eret | state==FLUSH.
- commit_ready = state==IDLE. In FLUSH, exc_valid and is_eret are forced 0 and ext_q keeps sampling.
- Reset: state=IDLE, counter=0, ext_q=0. All outputs 0 except commit_ready=1 and exc_location, which tracks its combinational inputs.
- Reset mid-FLUSH returns to IDLE on the next edge.

Optional Feature:
- EXC_INT_SYNC_EN defined: ext_int passes through a 2-flop synchronizer, giving 2-cycle latency to interrupt_info.
- Undefined: single register, 1-cycle latency.

Test Plan:
- Reset, then ext_int=6'b000001, IM=8'h04, IE=1, EXL=0, commit_valid=1, pc=32'h80001000 → after sync latency: exc_valid=1, code=0, location=32'h80000180, flush high for 1+FLUSH_CYCLES cycles, commit_ready low for FLUSH_CYCLES.
- f_ov and f_ades together, BEV=1, pc=32'hBFC00010 → code=12, location=32'hBFC00380, badvaddr=0.
- f_tlbl, f_refill_mem, vaddr=32'h00400004, EXL=0 → code=2, location=32'h80000000, badvaddr=32'h00400004. Repeat with EXL=1 → location=32'h80000180.
- f_eret only → is_eret=1, exc_valid=0, flush=1. f_eret+f_sys → exc_valid=1, code=8, is_eret=0.
- f_cpu, f_ce=1, in_delay_slot=1, pc=32'h80002004 → code=11, exc_ce=1, exc_in_delay_slot=1, exc_pc=32'h80002004.
- Second f_sys during FLUSH → no exc_valid; resetn=0 mid-FLUSH → commit_ready=1 next cycle.
